// File: rtl/vision_pkg.sv
// Types shared between the raster framer and the downstream vision filter stages.
package vision_pkg;

    typedef logic [1:0] pix_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_flags_t;

    localparam int FLAGS_W = $bits(pix_flags_t);

endpackage

// File: rtl/elastic.sv
// Single-entry ready/valid pipeline register; a new beat may load while the held one leaves.
module elastic #(
    parameter int width_p          = 8,
    parameter bit datapath_gate_p  = 1'b0,
    parameter bit datapath_reset_p = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i
);

    logic               r_valid;
    logic [width_p-1:0] r_data;
    logic               w_load;

    assign ready_o = !r_valid || ready_i;
    assign w_load  = datapath_gate_p ? (valid_i && ready_o) : ready_o;
    assign valid_o = r_valid;
    assign data_o  = r_data;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= 1'b0;
        end else if (ready_o) begin
            r_valid <= valid_i;
        end
    end

    if (datapath_reset_p) begin : g_data_rst
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                r_data <= '0;
            end else if (w_load) begin
                r_data <= data_i;
            end
        end
    end else begin : g_data_nrst
        always_ff @(posedge clk_i) begin
            if (w_load) begin
                r_data <= data_i;
            end
        end
    end

endmodule

// File: rtl/pixel_framer.sv
// Tags each 2-bit pixel with its raster position and frame markers, and counts completed frames.
module pixel_framer
    import vision_pkg::*;
#(
    parameter  int width_p  = 160,
    parameter  int height_p = 120,
    localparam int xw_lp    = $clog2(width_p),
    localparam int yw_lp    = ($clog2(height_p) > 1) ? $clog2(height_p) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [1:0]       data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             restart_i,
    output logic [1:0]       data_o,
    output logic [xw_lp-1:0] x_o,
    output logic [yw_lp-1:0] y_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic             eof_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [7:0]       frame_count_o
);

    localparam int PAY_W = 2 + xw_lp + yw_lp + FLAGS_W;

    logic [xw_lp-1:0] r_x;
    logic [yw_lp-1:0] r_y;
    logic [7:0]       r_frame_count;

    logic             w_x_last;
    logic             w_y_last;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_elastic_ready;
    logic             w_elastic_reset;
    pix_t             w_pix_in;
    pix_t             w_pix_out;
    pix_flags_t       w_flags_in;
    pix_flags_t       w_flags_out;
    logic [PAY_W-1:0] w_payload_in;
    logic [PAY_W-1:0] w_payload_out;

    assign w_x_last = (r_x == xw_lp'(width_p - 1));
    assign w_y_last = (r_y == yw_lp'(height_p - 1));

    assign w_flags_in.sof = (r_x == '0) && (r_y == '0);
    assign w_flags_in.eol = w_x_last;
    assign w_flags_in.eof = w_x_last && w_y_last;

    assign w_pix_in     = pix_t'(data_i);
    assign w_payload_in = {w_pix_in, r_x, r_y, w_flags_in};

    // A restart blocks acceptance this cycle and flushes the held beat through the register reset.
    assign ready_o         = !restart_i && w_elastic_ready;
    assign w_in_fire       = valid_i && ready_o;
    assign w_out_fire      = valid_o && ready_i;
    assign w_elastic_reset = reset_i || restart_i;

    elastic #(
        .width_p          (PAY_W),
        .datapath_gate_p  (1'b1),
        .datapath_reset_p (1'b1)
    ) u_out_reg (
        .clk_i   (clk_i),
        .reset_i (w_elastic_reset),
        .data_i  (w_payload_in),
        .valid_i (valid_i),
        .ready_o (w_elastic_ready),
        .data_o  (w_payload_out),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    assign {w_pix_out, x_o, y_o, w_flags_out} = w_payload_out;
    assign data_o = w_pix_out;
    assign sof_o  = w_flags_out.sof;
    assign eol_o  = w_flags_out.eol;
    assign eof_o  = w_flags_out.eof;

    always_ff @(posedge clk_i) begin
        if (reset_i || restart_i) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_in_fire) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + yw_lp'(1);
            end else begin
                r_x <= r_x + xw_lp'(1);
            end
        end
    end

    // A beat dropped by restart never counts, even if its eof was firing.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_frame_count <= 8'd0;
        end else if (!restart_i && w_out_fire && eof_o) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count_o = r_frame_count;

endmodule

// File: tb/tb_pixel_framer.sv
// Directed bench for pixel_framer on a 4x2 raster, plus a long random-handshake wrap run.
module tb_pixel_framer;

    localparam int W = 4;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [1:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       restart_i;
    logic [1:0] data_o;
    logic [1:0] x_o;
    logic [0:0] y_o;
    logic       sof_o;
    logic       eol_o;
    logic       eof_o;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] frame_count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] codes [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    int         exp_x [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int         exp_y [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int         exp_f [8] = '{4, 0, 0, 2, 0, 0, 0, 3};   // {sof,eol,eof}

    always #5 clk = ~clk;

    pixel_framer #(
        .width_p  (W),
        .height_p (H)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .restart_i     (restart_i),
        .data_o        (data_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .sof_o         (sof_o),
        .eol_o         (eol_o),
        .eof_o         (eof_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .frame_count_o (frame_count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input int d, input int x, input int y, input int f);
        check({tag, ".valid"}, 32'(valid_o), 32'd1);
        check({tag, ".data"},  32'(data_o),  32'(d));
        check({tag, ".x"},     32'(x_o),     32'(x));
        check({tag, ".y"},     32'(y_o),     32'(y));
        check({tag, ".flags"}, 32'({sof_o, eol_o, eof_o}), 32'(f));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ev;
        bit         rdy;
        bit         in_f;
        bit         out_f;
        logic [1:0] ed;
        int         ex, ey, ef;
        int         mx, my, sent, guard;
        logic [7:0] efc;
        int         total;

        reset_i   = 1'b1;
        restart_i = 1'b0;
        valid_i   = 1'b0;
        data_i    = 2'd0;
        ready_i   = 1'b1;

        // Reset state
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.ready", 32'(ready_o), 32'd1);
        check("rst.fc",    32'(frame_count_o), 32'd0);
        check("rst.outs",  32'({data_o, x_o, y_o, sof_o, eol_o, eof_o}), 32'd0);

        // Full frame, back to back
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = codes[i];
            tick();
            chk_beat($sformatf("f1[%0d]", i), int'(codes[i]), exp_x[i], exp_y[i], exp_f[i]);
        end
        valid_i = 1'b0;
        tick();
        check("f1.idle", 32'(valid_o), 32'd0);
        check("f1.fc",   32'(frame_count_o), 32'd1);

        // Backpressure after beat 1
        valid_i = 1'b1;
        data_i  = codes[0];
        tick();
        chk_beat("bp[0]", int'(codes[0]), 0, 0, 4);
        ready_i = 1'b0;
        data_i  = codes[1];
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp.ready[%0d]", k), 32'(ready_o), 32'd0);
            tick();
            chk_beat($sformatf("bp.hold[%0d]", k), int'(codes[0]), 0, 0, 4);
        end
        ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            data_i = codes[i];
            tick();
            chk_beat($sformatf("bp[%0d]", i), int'(codes[i]), exp_x[i], exp_y[i], exp_f[i]);
        end
        valid_i = 1'b0;
        tick();
        check("bp.idle", 32'(valid_o), 32'd0);
        check("bp.fc",   32'(frame_count_o), 32'd2);

        // Restart with a held beat after 5 pixels
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            data_i  = codes[i];
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        tick();
        chk_beat("rs.hold", int'(codes[4]), 0, 1, 0);
        restart_i = 1'b1;
        #1;
        check("rs.ready_lo", 32'(ready_o), 32'd0);
        tick();
        restart_i = 1'b0;
        #1;
        check("rs.dropped", 32'(valid_o), 32'd0);
        check("rs.fc",      32'(frame_count_o), 32'd2);
        check("rs.ready",   32'(ready_o), 32'd1);
        valid_i = 1'b1;
        data_i  = 2'd2;
        ready_i = 1'b1;
        tick();
        chk_beat("rs.first", 2, 0, 0, 4);
        valid_i = 1'b0;
        tick();

        // Restart in the same cycle as an input beat
        valid_i   = 1'b1;
        data_i    = 2'd3;
        restart_i = 1'b1;
        #1;
        check("rvi.ready", 32'(ready_o), 32'd0);
        tick();
        restart_i = 1'b0;
        check("rvi.none", 32'(valid_o), 32'd0);
        tick();
        chk_beat("rvi.first", 3, 0, 0, 4);
        valid_i = 1'b0;
        tick();

        // Restart overriding an eof output fire
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = codes[i];
            tick();
        end
        chk_beat("rse.eof", int'(codes[7]), 3, 1, 3);
        valid_i   = 1'b0;
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
        check("rse.dropped", 32'(valid_o), 32'd0);
        tick();
        check("rse.fc", 32'(frame_count_o), 32'd2);

        // 257 frames under random handshakes
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        ev    = 1'b0;
        ed    = 2'd0;
        ex    = 0;
        ey    = 0;
        ef    = 0;
        mx    = 0;
        my    = 0;
        sent  = 0;
        guard = 0;
        efc   = 8'd0;
        total = 257 * W * H;
        while ((sent < total || ev) && guard < 40000) begin
            valid_i = (sent < total) ? ($urandom_range(0, 3) != 0) : 1'b0;
            data_i  = 2'($urandom_range(0, 3));
            ready_i = ($urandom_range(0, 3) != 0);
            #1;
            rdy = !ev || ready_i;
            check("wrap.ready", 32'(ready_o), 32'(rdy));
            out_f = ev && ready_i;
            in_f  = valid_i && rdy;
            if (out_f && (ef & 1) != 0) efc = efc + 8'd1;
            if (in_f) begin
                ed = data_i;
                ex = mx;
                ey = my;
                ef = ((mx == 0 && my == 0) ? 4 : 0) | ((mx == W - 1) ? 2 : 0) |
                     ((mx == W - 1 && my == H - 1) ? 1 : 0);
                if (mx == W - 1) begin
                    mx = 0;
                    my = (my == H - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
                ev = 1'b1;
                sent++;
            end else if (out_f) begin
                ev = 1'b0;
            end
            tick();
            check("wrap.valid", 32'(valid_o), 32'(ev));
            if (ev) begin
                check("wrap.data",  32'(data_o), 32'(ed));
                check("wrap.pos",   32'({x_o, y_o}), 32'((ex << 1) | ey));
                check("wrap.flags", 32'({sof_o, eol_o, eof_o}), 32'(ef));
            end
            check("wrap.fc", 32'(frame_count_o), 32'(efc));
            guard++;
        end
        check("wrap.sent", 32'(sent), 32'(total));
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        check("wrap.fc_final", 32'(frame_count_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
